// File: rtl/gradient_magnitude.sv
// rtl/gradient_magnitude.sv - two-stage gradient magnitude with saturation and overflow counting
module gradient_magnitude #(
   parameter int PIXEL_SIZE = 12,
   parameter int IN_W       = PIXEL_SIZE + 6,
   parameter int SATURATE   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       gx,
   input  logic [IN_W-1:0]       gy,
   input  logic [1:0]            mode,
   input  logic [PIXEL_SIZE-1:0] threshold,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [PIXEL_SIZE-1:0] outPixel,
   output logic                  valid_out,
   input  logic                  ready_in,
   input  logic                  clear,
   output logic [CNT_W-1:0]      sat_count
);

   // Largest representable pixel, widened to the combine-stage width.
   localparam logic [IN_W:0]      PIX_MAX = {{(IN_W+1-PIXEL_SIZE){1'b0}}, {PIXEL_SIZE{1'b1}}};
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   // Stage 1: absolute values plus the mode/threshold captured with the beat.
   logic                  s1_v;
   logic [IN_W-1:0]       s1_ax;
   logic [IN_W-1:0]       s1_ay;
   logic [1:0]            s1_mode;
   logic [PIXEL_SIZE-1:0] s1_thr;

   // Stage 2: final pixel and whether this beat overflowed.
   logic                  s2_v;
   logic                  s2_ovf;

   logic adv1;
   logic adv2;

   // Combine-stage intermediates.
   logic [IN_W:0]         sum;
   logic [IN_W:0]         thr_ext;
   logic [IN_W:0]         mag;
   logic                  ovf;
   logic [PIXEL_SIZE-1:0] pix;

   // Two's-complement magnitude; the most negative input yields 2^(IN_W-1) as unsigned.
   function automatic logic [IN_W-1:0] abs_val(input logic [IN_W-1:0] v);
      return v[IN_W-1] ? ((~v) + IN_W'(1)) : v;
   endfunction

   assign adv2      = ~s2_v | ready_in;
   assign adv1      = ~s1_v | adv2;
   assign ready_out = adv1;
   assign valid_out = s2_v;

   // Combine the two magnitudes and decide overflow against the pixel range.
   always_comb begin
      sum     = {1'b0, s1_ax} + {1'b0, s1_ay};
      thr_ext = {{(IN_W+1-PIXEL_SIZE){1'b0}}, s1_thr};
      mag     = '0;
      case (s1_mode)
         2'd0:    mag = {1'b0, s1_ax};
         2'd1:    mag = sum;
         2'd2:    mag = (s1_ay > s1_ax) ? {1'b0, s1_ay} : {1'b0, s1_ax};
         default: mag = (sum >= thr_ext) ? PIX_MAX : '0;
      endcase
      ovf = (mag > PIX_MAX);
      pix = ((SATURATE != 0) && ovf) ? {PIXEL_SIZE{1'b1}} : mag[PIXEL_SIZE-1:0];
   end

   // Stage 1 register: takes a new beat whenever it is empty or can hand its beat on.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_ax   <= '0;
         s1_ay   <= '0;
         s1_mode <= '0;
         s1_thr  <= '0;
      end else if (adv1) begin
         s1_v <= valid_in;
         if (valid_in) begin
            s1_ax   <= abs_val(gx);
            s1_ay   <= abs_val(gy);
            s1_mode <= mode;
            s1_thr  <= threshold;
         end
      end
   end

   // Stage 2 register: output pixel holds steady while the writer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v     <= 1'b0;
         s2_ovf   <= 1'b0;
         outPixel <= '0;
      end else if (adv2) begin
         s2_v <= s1_v;
         if (s1_v) begin
            outPixel <= pix;
            s2_ovf   <= ovf;
         end
      end
   end

   // Sticky overflow counter counted at output transfer; clear takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count <= '0;
      end else if (clear) begin
         sat_count <= '0;
      end else if (s2_v && ready_in && s2_ovf && (sat_count != CNT_MAX)) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gradient_magnitude.sv
// tb/tb_gradient_magnitude.sv - directed and randomized checks of gradient_magnitude
module tb_gradient_magnitude;

   localparam int PS = 12;
   localparam int IW = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [IW-1:0] gx;
   logic [IW-1:0] gy;
   logic [1:0]    mode;
   logic [PS-1:0] threshold;
   logic          valid_in;
   logic          ready_in;
   logic          clear;

   logic          ready_out_a, valid_out_a;
   logic [PS-1:0] pix_a;
   logic [15:0]   cnt_a;
   logic          ready_out_b, valid_out_b;
   logic [PS-1:0] pix_b;
   logic [1:0]    cnt_b;

   gradient_magnitude #(.PIXEL_SIZE(PS), .IN_W(IW), .SATURATE(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .gx(gx), .gy(gy), .mode(mode), .threshold(threshold),
      .valid_in(valid_in), .ready_out(ready_out_a), .outPixel(pix_a), .valid_out(valid_out_a),
      .ready_in(ready_in), .clear(clear), .sat_count(cnt_a));

   gradient_magnitude #(.PIXEL_SIZE(PS), .IN_W(IW), .SATURATE(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .gx(gx), .gy(gy), .mode(mode), .threshold(threshold),
      .valid_in(valid_in), .ready_out(ready_out_b), .outPixel(pix_b), .valid_out(valid_out_b),
      .ready_in(ready_in), .clear(clear), .sat_count(cnt_b));

   typedef struct {
      int t;
      int a;
      int b;
      bit ovf;
   } beat_t;

   beat_t q[$];
   int    got[$];
   int    passed = 0;
   int    failed = 0;
   int    total  = 0;
   int    cyc_n  = 0;
   int    m_cnt_a = 0;
   int    m_cnt_b = 0;
   bit    acc;
   int    cur_x, cur_y, cur_md, cur_th;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input int x, input int y, input int md, input int th, input int t);
      beat_t r;
      int ax, ay, m;
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      case (md)
         0:       m = ax;
         1:       m = ax + ay;
         2:       m = (ay > ax) ? ay : ax;
         default: m = (ax + ay >= th) ? 4095 : 0;
      endcase
      r.t   = t;
      r.ovf = (m > 4095);
      r.a   = r.ovf ? 4095 : m;
      r.b   = m % 4096;
      return r;
   endfunction

   task automatic drive(input int x, input int y, input int md, input int th, input bit v);
      cur_x = x; cur_y = y; cur_md = md; cur_th = th;
      gx = IW'(x);
      gy = IW'(y);
      mode = 2'(md);
      threshold = PS'(th);
      valid_in = v;
   endtask

   // One clock: check outputs against the queue model, then advance the model across the edge.
   task automatic cyc();
      bit    exp_r, exp_v, in_x, out_x;
      beat_t b;
      #1;
      exp_r = !(q.size() >= 2 && !ready_in);
      exp_v = (q.size() > 0) && (cyc_n - q[0].t >= 2);
      if (!rst) begin
         chk("ready_out_a", 32'(ready_out_a), 32'(exp_r));
         chk("ready_out_b", 32'(ready_out_b), 32'(exp_r));
         chk("valid_out_a", 32'(valid_out_a), 32'(exp_v));
         chk("valid_out_b", 32'(valid_out_b), 32'(exp_v));
         if (exp_v) begin
            chk("pixel_a", 32'(pix_a), q[0].a);
            chk("pixel_b", 32'(pix_b), q[0].b);
         end
         chk("sat_count_a", 32'(cnt_a), m_cnt_a);
         chk("sat_count_b", 32'(cnt_b), m_cnt_b);
         if (valid_out_a && ready_in) got.push_back(int'(pix_a));
      end
      in_x  = valid_in && exp_r && !rst;
      out_x = exp_v && ready_in && !rst;
      acc   = in_x;
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         m_cnt_a = 0;
         m_cnt_b = 0;
      end else begin
         if (out_x) begin
            b = q.pop_front();
            if (b.ovf) begin
               if (m_cnt_a < 65535) m_cnt_a++;
               if (m_cnt_b < 3) m_cnt_b++;
            end
         end
         if (clear) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
         end
         if (in_x) q.push_back(mk(cur_x, cur_y, cur_md, cur_th, cyc_n));
      end
      cyc_n++;
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 1'b0);
      for (int k = 0; k < 20 && q.size() > 0; k++) cyc();
      cyc();
      chk("drain_empty", 32'(q.size()), 0);
   endtask

   int e3[5] = '{700, 0, 4095, 30, 20};
   int idx;

   initial begin
      rst = 1'b1; ready_in = 1'b1; clear = 1'b0;
      drive(0, 0, 0, 0, 1'b0);
      cyc(); cyc();
      rst = 1'b0;

      // Reset state
      chk("rst_valid_out", 32'(valid_out_a), 0);
      chk("rst_pixel", 32'(pix_a), 0);
      chk("rst_sat_count", 32'(cnt_a), 0);
      chk("rst_ready_out", 32'(ready_out_a), 1);

      // Mode 1 sum with 2-cycle latency
      drive(-100, 50, 1, 0, 1'b1); cyc();
      chk("s1_accept", 32'(acc), 1);
      drive(0, 0, 0, 0, 1'b0); cyc();
      chk("s1_valid", 32'(valid_out_a), 1);
      chk("s1_pixel", 32'(pix_a), 150);
      cyc();
      chk("s1_sat_count", 32'(cnt_a), 0);

      // Most negative input in mode 0, clamped vs wrapped
      drive(-131072, 0, 0, 0, 1'b1); cyc();
      drive(0, 0, 0, 0, 1'b0); cyc();
      chk("s2_pixel_sat", 32'(pix_a), 4095);
      chk("s2_pixel_wrap", 32'(pix_b), 0);
      cyc();
      chk("s2_cnt_a", 32'(cnt_a), 1);
      chk("s2_cnt_b", 32'(cnt_b), 1);

      // Max, threshold edges, and per-beat mode switching
      got.delete();
      drive(300, -700, 2, 0, 1'b1); cyc();
      drive(200, -299, 3, 500, 1'b1); cyc();
      drive(200, -300, 3, 500, 1'b1); cyc();
      drive(10, 20, 1, 0, 1'b1); cyc();
      drive(10, 20, 2, 0, 1'b1); cyc();
      drain();
      chk("s3_count", 32'(got.size()), 5);
      for (int i = 0; i < 5; i++) chk("s3_value", (i < got.size()) ? got[i] : -1, e3[i]);

      // Backpressure: 4 stalled cycles while streaming 1..5
      got.delete();
      ready_in = 1'b0;
      idx = 1;
      for (int k = 0; k < 4; k++) begin
         drive(idx, 0, 0, 0, 1'b1);
         if (k >= 2) begin
            #1;
            chk("s4_ready_low", 32'(ready_out_a), 0);
            chk("s4_hold_valid", 32'(valid_out_a), 1);
            chk("s4_hold_pixel", 32'(pix_a), 1);
         end
         cyc();
         if (acc) idx++;
      end
      ready_in = 1'b1;
      for (int k = 0; k < 30 && idx <= 5; k++) begin
         drive(idx, 0, 0, 0, 1'b1);
         cyc();
         if (acc) idx++;
      end
      chk("s4_all_sent", idx, 6);
      drain();
      chk("s4_count", 32'(got.size()), 5);
      for (int i = 0; i < 5; i++) chk("s4_order", (i < got.size()) ? got[i] : -1, i + 1);

      // Counter: accumulate, clear collision, and sticky limit
      clear = 1'b1; drive(0, 0, 0, 0, 1'b0); cyc(); clear = 1'b0;
      chk("s5_cleared", 32'(cnt_a), 0);
      for (int k = 0; k < 3; k++) begin drive(5000, 0, 0, 0, 1'b1); cyc(); end
      drain();
      chk("s5_cnt3_a", 32'(cnt_a), 3);
      chk("s5_cnt3_b", 32'(cnt_b), 3);
      drive(5000, 0, 0, 0, 1'b1); cyc();
      drive(0, 0, 0, 0, 1'b0); cyc();
      chk("s5_ovf_present", 32'(valid_out_a), 1);
      clear = 1'b1; cyc(); clear = 1'b0;
      chk("s5_clear_wins_a", 32'(cnt_a), 0);
      chk("s5_clear_wins_b", 32'(cnt_b), 0);
      for (int k = 0; k < 5; k++) begin drive(-6000, 0, 0, 0, 1'b1); cyc(); end
      drain();
      chk("s5_cnt5_a", 32'(cnt_a), 5);
      chk("s5_sticky_b", 32'(cnt_b), 3);

      // Reset with two beats in flight
      ready_in = 1'b0;
      drive(11, 0, 0, 0, 1'b1); cyc();
      drive(12, 0, 0, 0, 1'b1); cyc();
      drive(0, 0, 0, 0, 1'b0);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("s6_valid_out", 32'(valid_out_a), 0);
      chk("s6_sat_count", 32'(cnt_a), 0);
      chk("s6_ready_out", 32'(ready_out_a), 1);
      got.delete();
      ready_in = 1'b1;
      drive(-7, 9, 1, 0, 1'b1); cyc();
      drive(0, 0, 0, 0, 1'b0); cyc();
      chk("s6_latency_valid", 32'(valid_out_a), 1);
      chk("s6_pixel", 32'(pix_a), 16);
      drain();
      chk("s6_no_stale", 32'(got.size()), 1);

      // Randomized traffic against the queue model
      for (int k = 0; k < 400; k++) begin
         int x, y;
         if ($urandom_range(0, 1) != 0) begin
            x = int'($urandom_range(0, 262143)) - 131072;
            y = int'($urandom_range(0, 262143)) - 131072;
         end else begin
            x = int'($urandom_range(0, 8000)) - 4000;
            y = int'($urandom_range(0, 8000)) - 4000;
         end
         if ($urandom_range(0, 40) == 0) x = -131072;
         ready_in = ($urandom_range(0, 3) != 0);
         clear = ($urandom_range(0, 30) == 0);
         drive(x, y, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
               $urandom_range(0, 3) != 0);
         cyc();
      end
      clear = 1'b0;
      ready_in = 1'b1;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
